function_area: RTL and testbench
================================

FUNCTION_AREA -- requirements
Module: function_area

Interface
REQ-001 The block SHALL take parameter MODE, default 2; selects computed quantity: 0 = circle area, 1 = square area, 2 = total (circle + square) area.
REQ-002 Port clk SHALL be input, 1 bit; rising-edge system clock.
REQ-003 Port reset SHALL be input, 1 bit; reset, synchronous, active-low.
REQ-004 Port width SHALL be input, 8 bits, unsigned; side length / diameter.
REQ-005 Port area SHALL be output, 17 bits, unsigned, registered; computed area.

Function
REQ-006 Square area SHALL be computed as sq = width*width, exact 16-bit unsigned (max 65025).
REQ-007 Circle area SHALL be computed as cir = floor(201*width*width / 256), using a 24-bit intermediate product and truncation; result is 16 bits (max 51054); 201/256 approximates pi/4 (circle of diameter width).
REQ-008 Total area SHALL be computed as tot = cir + sq in 17 bits (max 116079), never overflowing.
REQ-009 MODE 0 SHALL drive area = {1'b0, cir}; MODE 1 SHALL drive area = {1'b0, sq}; MODE 2 SHALL drive area = tot.
REQ-010 Each quantity SHALL be implemented as a dedicated function (square, circle, total), with total built by calling the other two; MODE SHALL be resolved at elaboration, not at run time.
REQ-011 area SHALL update on every rising clk edge with reset high, from the width sampled at that same edge; latency is exactly 1 cycle.
REQ-012 No enable or handshake SHALL exist; area tracks width continuously with 1-cycle delay.
REQ-013 Division by 256 SHALL be a truncating right shift by 8 (floor), with no rounding.
REQ-014 Unsupported MODE values (3 and above) SHALL behave as MODE 2.

Reset
REQ-015 While reset is low at a rising clk edge, area SHALL be loaded with 17'd0, regardless of width.
REQ-016 Reset SHALL have no asynchronous effect; reset deasserting between edges takes effect at the next rising edge.
REQ-017 Reset asserted mid-stream SHALL clear area at the next edge; the first edge with reset high then loads the result for the current width.
REQ-018 At power-up before the first reset edge, area SHALL be undefined (X allowed in simulation).

Verification
REQ-019 Hold reset low for 2 edges with width=8'd200 -> area=0 in all modes.
REQ-020 width=0, 10, 16 -> MODE0: 0, 78, 201; MODE1: 0, 100, 256; MODE2: 0, 178, 457; each appears 1 cycle after sampling.
REQ-021 width=255 -> MODE0: 51054; MODE1: 65025; MODE2: 116079 (bit 16 set, no wrap).
REQ-022 width driven by a free-running 8-bit counter 0..255 with wrap to 0 -> every cycle area equals the REQ-006..REQ-009 model of the previous-edge width, including the 255->0 transition.
REQ-023 Pull reset low for one edge during the counter sweep -> area=0 at that edge; the following edge returns the model value for the current width.

Source files
------------

// File: rtl/function_area.sv
// function_area: registered area of a circle (diameter = width), a square
// (side = width) or their sum, selected at elaboration by MODE.
// One cycle of latency from width to area; synchronous active-low reset.
module function_area #(
   parameter int unsigned MODE = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  width,
   output logic [16:0] area
);

   // Exact square of the side length; 255*255 = 65025 fits in 16 bits.
   function automatic logic [15:0] square(input logic [7:0] w);
      return {8'd0, w} * {8'd0, w};
   endfunction

   // pi/4 approximated as 201/256; the 24-bit product is floored by dropping
   // the low byte (201*65025 = 13070025 < 2^24, so nothing is lost on top).
   function automatic logic [15:0] circle(input logic [7:0] w);
      logic [23:0] p;
      p = 24'd201 * {16'd0, w} * {16'd0, w};
      return p[23:8];
   endfunction

   // Sum widened to 17 bits so the largest case (116079) cannot wrap.
   function automatic logic [16:0] total(input logic [7:0] w);
      return {1'b0, circle(w)} + {1'b0, square(w)};
   endfunction

   logic [16:0] next_area;

   // Quantity chosen at elaboration; any MODE other than 0 or 1 yields total.
   if (MODE == 0) begin : g_circle
      always_comb next_area = {1'b0, circle(width)};
   end else if (MODE == 1) begin : g_square
      always_comb next_area = {1'b0, square(width)};
   end else begin : g_total
      always_comb next_area = total(width);
   end

   // Output register: cleared while reset is low, otherwise tracks width.
   always_ff @(posedge clk) begin
      if (!reset) area <= '0;
      else        area <= next_area;
   end

endmodule

// File: tb/tb_function_area.sv
// Bench for function_area: one instance per MODE (0, 1, 2 and unsupported 3)
// sharing clk/reset/width, compared against an arithmetic area model.
module tb_function_area;

   logic        clk;
   logic        reset;
   logic [7:0]  width;
   logic [16:0] area0, area1, area2, area3;
   logic [16:0] got [4];

   int total_cnt = 0;
   int bad_cnt   = 0;

   function_area #(.MODE(0)) u_m0 (.clk(clk), .reset(reset), .width(width), .area(area0));
   function_area #(.MODE(1)) u_m1 (.clk(clk), .reset(reset), .width(width), .area(area1));
   function_area            u_m2 (.clk(clk), .reset(reset), .width(width), .area(area2));
   function_area #(.MODE(3)) u_m3 (.clk(clk), .reset(reset), .width(width), .area(area3));

   assign got[0] = area0;
   assign got[1] = area1;
   assign got[2] = area2;
   assign got[3] = area3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the stated formulas.
   function automatic int model(input int mode, input int w);
      int c, s;
      s = w * w;
      c = (201 * w * w) / 256;
      case (mode)
         0:       return c;
         1:       return s;
         default: return c + s;
      endcase
   endfunction

   // Drive inputs on the falling edge, then wait for the rising edge to pass.
   task automatic drive_edge(input logic [7:0] w, input logic r);
      @(negedge clk);
      width = w;
      reset = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int e = 0; e < 2; e++) begin
         drive_edge(8'd200, 1'b0);
         for (int m = 0; m < 4; m++) begin
            total_cnt++;
            if (got[m] !== 17'd0) begin
               bad_cnt++;
               $display("FAIL reset mode=%0d edge=%0d got=%0d want=0", m, e, got[m]);
            end
         end
      end
   endtask

   task automatic test_vectors();
      int widths [4] = '{0, 10, 16, 255};
      int want [4][4] = '{'{0, 78, 201, 51054},
                          '{0, 100, 256, 65025},
                          '{0, 178, 457, 116079},
                          '{0, 178, 457, 116079}};
      for (int i = 0; i < 4; i++) begin
         drive_edge(8'(widths[i]), 1'b1);
         for (int m = 0; m < 4; m++) begin
            total_cnt++;
            if (got[m] !== 17'(want[m][i])) begin
               bad_cnt++;
               $display("FAIL vector mode=%0d width=%0d got=%0d want=%0d",
                        m, widths[i], got[m], want[m][i]);
            end
         end
      end
   endtask

   task automatic test_sweep();
      int w;
      for (int i = 0; i < 260; i++) begin
         w = i % 256;
         drive_edge(8'(w), 1'b1);
         for (int m = 0; m < 4; m++) begin
            total_cnt++;
            if (got[m] !== 17'(model(m, w))) begin
               bad_cnt++;
               $display("FAIL sweep mode=%0d width=%0d got=%0d want=%0d",
                        m, w, got[m], model(m, w));
            end
         end
      end
   endtask

   task automatic test_random();
      int w;
      for (int i = 0; i < 100; i++) begin
         w = int'($urandom_range(255, 0));
         drive_edge(8'(w), 1'b1);
         for (int m = 0; m < 4; m++) begin
            total_cnt++;
            if (got[m] !== 17'(model(m, w))) begin
               bad_cnt++;
               $display("FAIL random mode=%0d width=%0d got=%0d want=%0d",
                        m, w, got[m], model(m, w));
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int w;
      logic r;
      int want;
      for (int i = 0; i < 40; i++) begin
         w = (100 + i) % 256;
         r = (i == 20) ? 1'b0 : 1'b1;
         drive_edge(8'(w), r);
         for (int m = 0; m < 4; m++) begin
            want = r ? model(m, w) : 0;
            total_cnt++;
            if (got[m] !== 17'(want)) begin
               bad_cnt++;
               $display("FAIL mid_reset mode=%0d width=%0d rst=%0b got=%0d want=%0d",
                        m, w, r, got[m], want);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      width = 8'd200;
      test_reset();
      test_vectors();
      test_sweep();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
